// File: rtl/mem_bus_responder.sv
// mem_bus_responder: CPU-bus target for WRAM/HRAM/IE/IF/FF46, external forwarding and OAM DMA.
module mem_bus_responder #(
    parameter int unsigned WRAM_AW    = 13,
    parameter int unsigned HRAM_DEPTH = 127,
    parameter int unsigned DMA_LEN    = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_tick,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] ext_addr,
    output logic        ext_wr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    input  logic [4:0]  irq_req,
    input  logic [4:0]  irq_ack,
    output logic        int_pending,
    output logic        dma_active
);
    localparam int unsigned WRAM_DEPTH = 2 ** WRAM_AW;
    localparam int unsigned HRAM_AW    = (HRAM_DEPTH > 1) ? $clog2(HRAM_DEPTH) : 1;
    localparam logic [7:0]  DMA_LAST   = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_ACTIVE} dma_state_e;
    typedef enum logic [2:0] {SEL_FF, SEL_WRAM, SEL_HRAM, SEL_IF, SEL_IE, SEL_DMA, SEL_EXT} rd_sel_e;

    dma_state_e state_q, state_d;
    rd_sel_e    rd_sel_q, rd_sel_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic       oam_we_d;
    logic [7:0] oam_addr_d, oam_wdata_d;
    logic [7:0] ie_q, ie_d;
    logic [4:0] if_q, if_d;
    logic [7:0] dma_reg_q;

    logic is_wram, is_hram, is_if, is_ie, is_dma_reg, is_ext;
    logic wr_cyc, wram_we, hram_we, if_we, ie_we, dma_we, ext_we;
    logic src_is_wram;
    logic [7:0] dma_byte;

    logic [7:0]         wram_mem [WRAM_DEPTH];
    logic [7:0]         hram_mem [HRAM_DEPTH];
    logic [7:0]         wram_rd_q, hram_rd_q;
    logic [WRAM_AW-1:0] wram_ra;
    logic [HRAM_AW-1:0] hram_idx;

    // Address decode; echo region E000-FDFF shares the low 13 bits with C000-DFFF
    always_comb begin
        is_wram    = (cpu_addr >= 16'hC000) && (cpu_addr <= 16'hFDFF);
        is_hram    = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
        is_if      = (cpu_addr == 16'hFF0F);
        is_ie      = (cpu_addr == 16'hFFFF);
        is_dma_reg = (cpu_addr == 16'hFF46);
        is_ext     = !(is_wram || is_hram || is_if || is_ie || is_dma_reg);
    end

    // Write qualification; DMA leaves the CPU only HRAM, IE and FF46
    always_comb begin
        wr_cyc  = m_tick & cpu_wr;
        wram_we = wr_cyc & is_wram & ~dma_active;
        hram_we = wr_cyc & is_hram;
        if_we   = wr_cyc & is_if & ~dma_active;
        ie_we   = wr_cyc & is_ie;
        dma_we  = wr_cyc & is_dma_reg;
        ext_we  = wr_cyc & is_ext & ~dma_active;
    end

    // DMA source selection: mirrored high bytes land in C0-DF and read from WRAM
    always_comb begin
        src_is_wram = (src_hi_q >= 8'hC0) && (src_hi_q <= 8'hDF);
        dma_byte    = src_is_wram ? wram_rd_q : ext_rdata;
        wram_ra     = dma_active ? WRAM_AW'({src_hi_q, idx_q}) : cpu_addr[WRAM_AW-1:0];
        hram_idx    = is_hram ? cpu_addr[HRAM_AW-1:0] : '0;
    end

    // WRAM: synchronous read, write on qualified m_tick only
    always_ff @(posedge clk) begin
        if (wram_we) begin
            wram_mem[cpu_addr[WRAM_AW-1:0]] <= cpu_wdata;
        end
        wram_rd_q <= wram_mem[wram_ra];
    end

    // HRAM: synchronous read, always reachable by the CPU
    always_ff @(posedge clk) begin
        if (hram_we) begin
            hram_mem[hram_idx] <= cpu_wdata;
        end
        hram_rd_q <= hram_mem[hram_idx];
    end

    // Read-source select for the next clk; blocked regions during DMA read FFh
    always_comb begin
        rd_sel_d = SEL_EXT;
        if (dma_active && !is_hram) begin
            rd_sel_d = SEL_FF;
        end else if (is_wram) begin
            rd_sel_d = SEL_WRAM;
        end else if (is_hram) begin
            rd_sel_d = SEL_HRAM;
        end else if (is_if) begin
            rd_sel_d = SEL_IF;
        end else if (is_ie) begin
            rd_sel_d = SEL_IE;
        end else if (is_dma_reg) begin
            rd_sel_d = SEL_DMA;
        end
    end

    // Interrupt registers; a request always wins over ack or CPU write
    always_comb begin
        ie_d = ie_we ? cpu_wdata : ie_q;
        if_d = (if_we ? cpu_wdata[4:0] : (if_q & ~irq_ack)) | irq_req;
    end

    // DMA next-state and OAM strobe; an FF46 write restarts from any state
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        src_hi_d    = src_hi_q;
        oam_we_d    = 1'b0;
        oam_addr_d  = oam_addr;
        oam_wdata_d = oam_wdata;
        if (dma_we) begin
            state_d  = DMA_START;
            idx_d    = '0;
            src_hi_d = (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;
        end else if (m_tick) begin
            case (state_q)
                DMA_START: begin
                    state_d = DMA_ACTIVE;
                    idx_d   = '0;
                end
                DMA_ACTIVE: begin
                    oam_we_d    = 1'b1;
                    oam_addr_d  = idx_q;
                    oam_wdata_d = dma_byte;
                    if (idx_q == DMA_LAST) begin
                        state_d = DMA_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DMA_IDLE;
            idx_q       <= '0;
            src_hi_q    <= '0;
            dma_active  <= 1'b0;
            oam_we      <= 1'b0;
            oam_addr    <= '0;
            oam_wdata   <= '0;
            ie_q        <= '0;
            if_q        <= '0;
            dma_reg_q   <= 8'hFF;
            int_pending <= 1'b0;
            rd_sel_q    <= SEL_FF;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            src_hi_q    <= src_hi_d;
            dma_active  <= (state_d != DMA_IDLE);
            oam_we      <= oam_we_d;
            oam_addr    <= oam_addr_d;
            oam_wdata   <= oam_wdata_d;
            ie_q        <= ie_d;
            if_q        <= if_d;
            if (dma_we) begin
                dma_reg_q <= cpu_wdata;
            end
            int_pending <= |(ie_d[4:0] & if_d);
            rd_sel_q    <= rd_sel_d;
        end
    end

    // CPU read mux driven by the source selected one clk earlier
    always_comb begin
        case (rd_sel_q)
            SEL_WRAM: cpu_rdata = wram_rd_q;
            SEL_HRAM: cpu_rdata = hram_rd_q;
            SEL_IF:   cpu_rdata = {3'b111, if_q};
            SEL_IE:   cpu_rdata = ie_q;
            SEL_DMA:  cpu_rdata = dma_reg_q;
            SEL_EXT:  cpu_rdata = ext_rdata;
            default:  cpu_rdata = 8'hFF;
        endcase
    end

    // External port: same-clk address and write strobe, held at zero in reset
    always_comb begin
        ext_addr  = '0;
        ext_wr    = 1'b0;
        ext_wdata = '0;
        if (rst_n) begin
            ext_addr  = dma_active ? {src_hi_q, idx_q} : cpu_addr;
            ext_wr    = ext_we;
            ext_wdata = ext_we ? cpu_wdata : 8'h00;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed checks of decode, read latency, IF/IE, OAM DMA and reset.
`timescale 1ns/1ps
module tb_mem_bus_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_tick;
    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] ext_addr;
    logic        ext_wr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic [4:0]  irq_req;
    logic [4:0]  irq_ack;
    logic        int_pending;
    logic        dma_active;

    int n_checks = 0;
    int n_errors = 0;
    int oam_cnt = 0;
    int exp_idx = 0;
    int act_mcyc = 0;
    int ext_wr_cnt = 0;
    int snap;
    logic [7:0] exp_src = 8'hC1;
    logic [7:0] ext_wdata_seen = 8'h00;

    mem_bus_responder dut (
        .clk(clk), .rst_n(rst_n), .m_tick(m_tick),
        .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ext_addr(ext_addr), .ext_wr(ext_wr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
        .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
        .irq_req(irq_req), .irq_ack(irq_ack), .int_pending(int_pending), .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] src, input int i);
        logic [7:0] b;
        b = 8'(i);
        return (src == 8'hC1) ? (b ^ 8'hA5) : (b ^ 8'h5A);
    endfunction

    // Every OAM strobe must follow the expected index order and source pattern
    always @(negedge clk) begin
        if (oam_we) begin
            check("oam_addr", 16'(oam_addr), 16'(exp_idx));
            check("oam_data", 16'(oam_wdata), 16'(exp_byte(exp_src, exp_idx)));
            exp_idx++;
            oam_cnt++;
        end
    end

    // One M-cycle of four clks, m_tick on the last; starts and ends just after a negedge
    task automatic mcycle();
        for (int t = 0; t < 4; t++) begin
            m_tick = (t == 3);
            #1;
            if (ext_wr) begin
                ext_wr_cnt++;
                ext_wdata_seen = ext_wdata;
            end
            if (m_tick && dma_active) act_mcyc++;
            @(negedge clk);
        end
        m_tick = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wr    = 1'b1;
        cpu_wdata = d;
        mcycle();
        cpu_wr = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        cpu_addr = a;
        cpu_wr   = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic run_until_idle();
        for (int k = 0; k < 200 && dma_active; k++) mcycle();
    endtask

    initial begin
        rst_n = 1'b0; m_tick = 1'b1; cpu_addr = 16'h1234; cpu_wr = 1'b1; cpu_wdata = 8'h00;
        ext_rdata = 8'h00; irq_req = '0; irq_ack = '0;
        #12;
        check("rst_rdata", 16'(cpu_rdata), 16'h00FF);
        check("rst_ext_addr", ext_addr, 16'h0000);
        check("rst_ext_wr", 16'(ext_wr), 16'h0000);
        check("rst_dma_active", 16'(dma_active), 16'h0000);
        check("rst_oam_we", 16'(oam_we), 16'h0000);
        check("rst_int_pending", 16'(int_pending), 16'h0000);
        m_tick = 1'b0; cpu_wr = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;

        // WRAM, echo and HRAM
        wr(16'hC123, 8'h5A);
        rd(16'hC123); check("wram_rd", 16'(cpu_rdata), 16'h005A);
        rd(16'hE123); check("echo_rd", 16'(cpu_rdata), 16'h005A);
        wr(16'hFDFF, 8'h11);
        rd(16'hDDFF); check("echo_wr", 16'(cpu_rdata), 16'h0011);
        wr(16'hC000, 8'h33);
        wr(16'hFF80, 8'h77);
        wr(16'hFFFE, 8'h3E);
        rd(16'hFFFE); check("hram_top", 16'(cpu_rdata), 16'h003E);
        rd(16'hFF80); check("hram_bot", 16'(cpu_rdata), 16'h0077);

        // OAM DMA from C100
        for (int i = 0; i < 160; i++) begin
            wr(16'hC100 + 16'(i), 8'(i) ^ 8'hA5);
            wr(16'hC200 + 16'(i), 8'(i) ^ 8'h5A);
        end
        act_mcyc = 0; oam_cnt = 0; exp_src = 8'hC1; exp_idx = 0;
        wr(16'hFF46, 8'hC1);
        check("dma_go", 16'(dma_active), 16'h0001);
        cpu_addr = 16'hC000; mcycle();
        check("dma_rd_wram", 16'(cpu_rdata), 16'h00FF);
        check("dma_ext_addr", 16'(ext_addr[15:8]), 16'h00C1);
        cpu_addr = 16'hFF80; mcycle();
        check("dma_rd_hram", 16'(cpu_rdata), 16'h0077);
        snap = ext_wr_cnt;
        wr(16'h8000, 8'h12);
        wr(16'hC000, 8'h99);
        check("dma_ext_wr_drop", 16'(ext_wr_cnt - snap), 16'h0000);
        run_until_idle();
        check("dma_done", 16'(dma_active), 16'h0000);
        check("dma_mcyc", 16'(act_mcyc), 16'd161);
        check("dma_oam_cnt", 16'(oam_cnt), 16'd160);
        rd(16'hC000); check("dma_wram_drop", 16'(cpu_rdata), 16'h0033);

        // Mirrored source and restart
        oam_cnt = 0; exp_src = 8'hC1; exp_idx = 0;
        wr(16'hFF46, 8'hE1);
        cpu_addr = 16'hFF46; mcycle();
        check("dma_rd_ff46", 16'(cpu_rdata), 16'h00FF);
        for (int k = 0; k < 200 && oam_cnt < 'h50; k++) mcycle();
        check("pre_restart_cnt", 16'(oam_cnt), 16'h0050);
        exp_src = 8'hC2; exp_idx = 0;
        wr(16'hFF46, 8'hC2);
        act_mcyc = 0;
        check("restart_active", 16'(dma_active), 16'h0001);
        run_until_idle();
        check("restart_done", 16'(dma_active), 16'h0000);
        check("restart_mcyc", 16'(act_mcyc), 16'd161);
        check("restart_oam_cnt", 16'(oam_cnt), 16'd240);
        rd(16'hFF46); check("ff46_readback", 16'(cpu_rdata), 16'h00C2);

        // IE / IF
        wr(16'hFFFF, 8'h05);
        irq_req = 5'h01; @(negedge clk); #1; irq_req = '0;
        rd(16'hFF0F); check("if_req", 16'(cpu_rdata), 16'h00E1);
        check("int_pend_set", 16'(int_pending), 16'h0001);
        cpu_addr = 16'hFF0F; cpu_wr = 1'b1; cpu_wdata = 8'h00;
        for (int t = 0; t < 4; t++) begin
            m_tick  = (t == 3);
            irq_req = (t == 3) ? 5'h04 : 5'h00;
            @(negedge clk); #1;
        end
        m_tick = 1'b0; irq_req = '0; cpu_wr = 1'b0;
        check("if_wr_vs_req", 16'(cpu_rdata), 16'h00E4);
        check("int_pend_bit2", 16'(int_pending), 16'h0001);
        irq_ack = 5'h04; @(negedge clk); #1; irq_ack = '0;
        check("if_ack", 16'(cpu_rdata), 16'h00E0);
        check("int_pend_clr", 16'(int_pending), 16'h0000);
        irq_req = 5'h02; irq_ack = 5'h02; @(negedge clk); #1; irq_req = '0; irq_ack = '0;
        check("if_req_ack_same", 16'(cpu_rdata), 16'h00E2);
        check("int_pend_masked", 16'(int_pending), 16'h0000);
        irq_ack = 5'h02; @(negedge clk); #1; irq_ack = '0;

        // External read latency and write strobe
        rd(16'hFFFF); check("ie_rd", 16'(cpu_rdata), 16'h0005);
        cpu_addr = 16'h8000; ext_rdata = 8'h3C; #1;
        check("ext_rd_early", 16'(cpu_rdata), 16'h0005);
        check("ext_addr_cpu", ext_addr, 16'h8000);
        @(negedge clk); #1;
        check("ext_rd", 16'(cpu_rdata), 16'h003C);
        snap = ext_wr_cnt;
        wr(16'h8000, 8'h9A);
        check("ext_wr_cnt", 16'(ext_wr_cnt - snap), 16'h0001);
        check("ext_wdata", 16'(ext_wdata_seen), 16'h009A);
        snap = ext_wr_cnt;
        wr(16'hC001, 8'h44);
        check("wram_no_ext_wr", 16'(ext_wr_cnt - snap), 16'h0000);

        // Reset in the middle of a DMA
        irq_req = 5'h01; @(negedge clk); #1; irq_req = '0;
        check("pre_rst_int", 16'(int_pending), 16'h0001);
        oam_cnt = 0; exp_src = 8'hC1; exp_idx = 0;
        wr(16'hFF46, 8'hC1);
        for (int k = 0; k < 200 && oam_cnt < 'h20; k++) mcycle();
        check("pre_rst_cnt", 16'(oam_cnt), 16'h0020);
        check("pre_rst_oam_we", 16'(oam_we), 16'h0001);
        rst_n = 1'b0; #1;
        check("rst_mid_dma_active", 16'(dma_active), 16'h0000);
        check("rst_mid_oam_we", 16'(oam_we), 16'h0000);
        check("rst_mid_rdata", 16'(cpu_rdata), 16'h00FF);
        check("rst_mid_int", 16'(int_pending), 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1; #1;
        snap = oam_cnt;
        repeat (4) mcycle();
        check("post_rst_no_oam", 16'(oam_cnt - snap), 16'h0000);
        check("post_rst_idle", 16'(dma_active), 16'h0000);
        rd(16'hFFFF); check("post_rst_ie", 16'(cpu_rdata), 16'h0000);
        rd(16'hFF0F); check("post_rst_if", 16'(cpu_rdata), 16'h00E0);
        rd(16'hFF46); check("post_rst_ff46", 16'(cpu_rdata), 16'h00FF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
